// File: rtl/ifm_chunk_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// ifm_chunk_pingpong_ctrl
//
// Sequencing controller for the double-buffered IFM non-padding chunk store.
// Two chunk banks are filled in turn from the IFM loader and then launched,
// one at a time, to the compute units. A bank is freed only after every
// enabled compute unit has reported that it consumed the chunk.
//
// Optional feature macro: IFM_CHUNK_CTRL_PERF_EN
//   defined   -> 16-bit saturating stall counters on perf_wr_stall_o and
//                perf_rd_stall_o
//   undefined -> both perf ports are tied to zero, no counter logic
//
// Ports
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   ld_valid_i       loader beat valid
//   ld_ready_o       controller can take a beat (registered state only)
//   ld_shift_i       chunk shift, captured on the first beat of a chunk
//   wr_valid_o       store write strobe (accepted beat)
//   wr_count_o       beat index inside the chunk being written
//   wr_sel_o         bank being filled
//   chunk_start_o    one-cycle launch pulse to the compute units
//   rd_sel_o         bank being read
//   shift_left_o     shift of the launched chunk
//   cu_en_i          quasi-static compute unit enables
//   cu_done_i        per-CU one-cycle "chunk consumed" pulse
//   bank_full_o      per bank: holds a full chunk not yet launched
//   perf_wr_stall_o  loader stall cycle counter
//   perf_rd_stall_o  read-side idle-without-data cycle counter
//
// Read FSM
//   state   | meaning
//   --------+-------------------------------------------------------------
//   R_IDLE  | waiting for bank[rp] to become FULL
//   R_START | chunk_start_o pulse, CU done pulses ignored
//   R_BUSY  | collecting done pulses; release bank[rp] when all enabled
//           | CUs have reported
//
// Bank state
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   B_EMPTY   | free, next accepted beat starts a new chunk
//   B_FILLING | partially written
//   B_FULL    | complete chunk, not yet launched
//   B_READING | launched, waiting for the compute units to finish
// ---------------------------------------------------------------------------
module ifm_chunk_pingpong_ctrl #(
   parameter int MEM_SIZE         = 128,
   parameter int BUS_SIZE         = 32,
   parameter int PREFIX_SUM_SIZE  = 32,
   parameter int COMPUTE_UNIT_NUM = 4,
   // derived, not meant to be overridden
   parameter int WR_CYC_NUM       = MEM_SIZE / BUS_SIZE,
   parameter int CW               = (WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1,
   parameter int SW               = $clog2(PREFIX_SUM_SIZE)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,

   input  logic                        ld_valid_i,
   output logic                        ld_ready_o,
   input  logic [SW-1:0]               ld_shift_i,

   output logic                        wr_valid_o,
   output logic [CW-1:0]               wr_count_o,
   output logic                        wr_sel_o,

   output logic                        chunk_start_o,
   output logic                        rd_sel_o,
   output logic [SW-1:0]               shift_left_o,

   input  logic [COMPUTE_UNIT_NUM-1:0] cu_en_i,
   input  logic [COMPUTE_UNIT_NUM-1:0] cu_done_i,

   output logic [1:0]                  bank_full_o,
   output logic [15:0]                 perf_wr_stall_o,
   output logic [15:0]                 perf_rd_stall_o
);

   typedef enum logic [1:0] {
      B_EMPTY   = 2'd0,
      B_FILLING = 2'd1,
      B_FULL    = 2'd2,
      B_READING = 2'd3
   } bank_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_BUSY  = 2'd2
   } rstate_e;

   localparam logic [CW-1:0] LAST_BEAT = CW'(WR_CYC_NUM - 1);

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   bank_e                         bank_q [2];
   bank_e                         bank_d [2];
   logic [SW-1:0]                 shift_q [2];
   logic [SW-1:0]                 shift_d [2];
   logic                          wp_q, wp_d;
   logic                          rp_q, rp_d;
   logic [CW-1:0]                 wr_count_q, wr_count_d;
   logic [COMPUTE_UNIT_NUM-1:0]   done_mask_q, done_mask_d;
   logic [SW-1:0]                 shift_left_q, shift_left_d;
   rstate_e                       rstate_q, rstate_d;

   // ------------------------------------------------------------------------
   // Shared decode
   // ------------------------------------------------------------------------
   logic                          wr_fire;
   logic                          rd_launch;
   logic                          rd_release;
   logic [COMPUTE_UNIT_NUM-1:0]   done_hit;
   logic                          done_all;

   // Ready depends only on registered bank state (plus reset), never on
   // ld_valid_i, so the loader sees no combinational loop through us.
   assign ld_ready_o = !rst_i &&
                       ((bank_q[wp_q] == B_EMPTY) || (bank_q[wp_q] == B_FILLING));
   assign wr_fire    = ld_valid_i && ld_ready_o;

   assign done_hit   = cu_done_i & cu_en_i;
   // Disabled CUs count as done; the current pulse is folded in so the
   // release happens at the edge after the final pulse, not one later.
   assign done_all   = &(done_mask_q | done_hit | ~cu_en_i);

   assign rd_launch  = (rstate_q == R_IDLE) && (bank_q[rp_q] == B_FULL);
   assign rd_release = (rstate_q == R_BUSY) && done_all;

   // ------------------------------------------------------------------------
   // Read FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rstate_q <= R_IDLE;
      end else begin
         rstate_q <= rstate_d;
      end
   end

   // ------------------------------------------------------------------------
   // Read FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      rstate_d = rstate_q;
      case (rstate_q)
         R_IDLE:  if (rd_launch)  rstate_d = R_START;
         R_START:                 rstate_d = R_BUSY;
         R_BUSY:  if (rd_release) rstate_d = R_IDLE;
         default:                 rstate_d = R_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Read FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      chunk_start_o = 1'b0;
      case (rstate_q)
         R_START: chunk_start_o = 1'b1;
         default: chunk_start_o = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Bank / pointer next-state
   // The write side only touches bank[wp] while it is EMPTY/FILLING and the
   // read side only touches bank[rp] while it is FULL/READING, so the two
   // updates below can never target the same bank in the same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      bank_d       = bank_q;
      shift_d      = shift_q;
      wp_d         = wp_q;
      rp_d         = rp_q;
      wr_count_d   = wr_count_q;
      done_mask_d  = done_mask_q;
      shift_left_d = shift_left_q;

      if (wr_fire) begin
         if (bank_q[wp_q] == B_EMPTY) begin
            bank_d[wp_q]  = B_FILLING;
            shift_d[wp_q] = ld_shift_i;
         end
         if (wr_count_q == LAST_BEAT) begin
            bank_d[wp_q] = B_FULL;
            wr_count_d   = '0;
            wp_d         = ~wp_q;
         end else begin
            wr_count_d   = wr_count_q + CW'(1);
         end
      end

      if (rd_launch) begin
         bank_d[rp_q] = B_READING;
         done_mask_d  = '0;
         shift_left_d = shift_q[rp_q];
      end

      if (rstate_q == R_BUSY) begin
         done_mask_d = done_mask_q | done_hit;
      end

      if (rd_release) begin
         bank_d[rp_q] = B_EMPTY;
         rp_d         = ~rp_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bank_q[0]    <= B_EMPTY;
         bank_q[1]    <= B_EMPTY;
         shift_q[0]   <= '0;
         shift_q[1]   <= '0;
         wp_q         <= 1'b0;
         rp_q         <= 1'b0;
         wr_count_q   <= '0;
         done_mask_q  <= '0;
         shift_left_q <= '0;
      end else begin
         bank_q       <= bank_d;
         shift_q      <= shift_d;
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         wr_count_q   <= wr_count_d;
         done_mask_q  <= done_mask_d;
         shift_left_q <= shift_left_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign wr_valid_o   = wr_fire;
   assign wr_count_o   = wr_count_q;
   assign wr_sel_o     = wp_q;
   assign rd_sel_o     = rp_q;
   assign shift_left_o = shift_left_q;
   assign bank_full_o  = {(bank_q[1] == B_FULL), (bank_q[0] == B_FULL)};

   // ------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------
`ifdef IFM_CHUNK_CTRL_PERF_EN
   logic [15:0] perf_wr_q, perf_wr_d;
   logic [15:0] perf_rd_q, perf_rd_d;
   logic        wr_stall;
   logic        rd_stall;

   assign wr_stall = ld_valid_i && !ld_ready_o;
   assign rd_stall = (rstate_q == R_IDLE) && (bank_q[rp_q] != B_FULL);

   always_comb begin
      perf_wr_d = perf_wr_q;
      perf_rd_d = perf_rd_q;
      if (wr_stall && (perf_wr_q != 16'hFFFF)) perf_wr_d = perf_wr_q + 16'd1;
      if (rd_stall && (perf_rd_q != 16'hFFFF)) perf_rd_d = perf_rd_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_wr_q <= '0;
         perf_rd_q <= '0;
      end else begin
         perf_wr_q <= perf_wr_d;
         perf_rd_q <= perf_rd_d;
      end
   end

   assign perf_wr_stall_o = perf_wr_q;
   assign perf_rd_stall_o = perf_rd_q;
`else
   assign perf_wr_stall_o = 16'h0000;
   assign perf_rd_stall_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ifm_chunk_pingpong_ctrl.sv
// Directed bench for ifm_chunk_pingpong_ctrl. Inputs change 1 time unit
// after each rising edge; outputs are checked 2 time units after it.
module tb_ifm_chunk_pingpong_ctrl;

   localparam int SW = 5;
   localparam int CW = 2;
   localparam int CU = 4;

`ifdef IFM_CHUNK_CTRL_PERF_EN
   localparam int PERF_ON = 1;
`else
   localparam int PERF_ON = 0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          ld_valid_i;
   logic          ld_ready_o;
   logic [SW-1:0] ld_shift_i;
   logic          wr_valid_o;
   logic [CW-1:0] wr_count_o;
   logic          wr_sel_o;
   logic          chunk_start_o;
   logic          rd_sel_o;
   logic [SW-1:0] shift_left_o;
   logic [CU-1:0] cu_en_i;
   logic [CU-1:0] cu_done_i;
   logic [1:0]    bank_full_o;
   logic [15:0]   perf_wr_stall_o;
   logic [15:0]   perf_rd_stall_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   ifm_chunk_pingpong_ctrl dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .ld_valid_i      (ld_valid_i),
      .ld_ready_o      (ld_ready_o),
      .ld_shift_i      (ld_shift_i),
      .wr_valid_o      (wr_valid_o),
      .wr_count_o      (wr_count_o),
      .wr_sel_o        (wr_sel_o),
      .chunk_start_o   (chunk_start_o),
      .rd_sel_o        (rd_sel_o),
      .shift_left_o    (shift_left_o),
      .cu_en_i         (cu_en_i),
      .cu_done_i       (cu_done_i),
      .bank_full_o     (bank_full_o),
      .perf_wr_stall_o (perf_wr_stall_o),
      .perf_rd_stall_o (perf_rd_stall_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to the next cycle; inputs may be driven right after this
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i      = 1'b1;
      ld_valid_i = 1'b0;
      ld_shift_i = '0;
      cu_en_i    = 4'hF;
      cu_done_i  = '0;

      // ---------------- reset ----------------
      cyc(); #1;
      chk("rst_ready", ld_ready_o, 0);
      cyc(); #1;
      chk("rst_ready2",   ld_ready_o,      0);
      chk("rst_wr_count", wr_count_o,      0);
      chk("rst_wr_sel",   wr_sel_o,        0);
      chk("rst_start",    chunk_start_o,   0);
      chk("rst_rd_sel",   rd_sel_o,        0);
      chk("rst_shift",    shift_left_o,    0);
      chk("rst_full",     bank_full_o,     0);
      chk("rst_perf_wr",  perf_wr_stall_o, 0);
      chk("rst_perf_rd",  perf_rd_stall_o, 0);

      // ---------------- 12-beat stream, no done pulses ----------------
      // c0: first cycle after reset, beat 0 of bank 0 with shift 5
      cyc();
      rst_i = 1'b0; ld_valid_i = 1'b1; ld_shift_i = 5'd5;
      #1;
      chk("c0_ready",    ld_ready_o, 1);
      chk("c0_wr_valid", wr_valid_o, 1);
      chk("c0_wr_count", wr_count_o, 0);
      chk("c0_wr_sel",   wr_sel_o,   0);

      for (int i = 1; i < 12; i++) begin
         cyc();
         ld_shift_i = (i == 4) ? 5'd3 : 5'd9;
         #1;
         chk($sformatf("s%0d_ready", i),    ld_ready_o,    (i < 8) ? 1 : 0);
         chk($sformatf("s%0d_wr_valid", i), wr_valid_o,    (i < 8) ? 1 : 0);
         chk($sformatf("s%0d_start", i),    chunk_start_o, (i == 5) ? 1 : 0);
         if (i < 8) begin
            chk($sformatf("s%0d_wr_count", i), wr_count_o, i % 4);
            chk($sformatf("s%0d_wr_sel", i),   wr_sel_o,   i / 4);
         end
         if (i == 4) chk("s4_full", bank_full_o, 2'b01);
         if (i == 5) begin
            chk("s5_rd_sel", rd_sel_o,     0);
            chk("s5_shift",  shift_left_o, 5);
            chk("s5_full",   bank_full_o,  2'b00);
         end
         if (i == 8) begin
            chk("s8_full",   bank_full_o, 2'b10);
            chk("s8_wr_sel", wr_sel_o,    0);
         end
      end

      // ---------------- done pulses, all CUs enabled ----------------
      cyc(); ld_valid_i = 1'b0; cu_done_i = 4'b0001; #1;
      chk("c12_perf_wr", perf_wr_stall_o, (PERF_ON != 0) ? 4 : 0);
      chk("c12_perf_rd", perf_rd_stall_o, (PERF_ON != 0) ? 4 : 0);
      chk("c12_rd_sel",  rd_sel_o,        0);
      chk("c12_ready",   ld_ready_o,      0);

      cyc(); cu_done_i = 4'b0101; #1;   // repeated CU0 pulse
      chk("c13_rd_sel", rd_sel_o,    0);
      chk("c13_full",   bank_full_o, 2'b10);

      cyc(); cu_done_i = 4'b0010; #1;
      chk("c14_rd_sel", rd_sel_o, 0);

      cyc(); cu_done_i = 4'b1000; #1;
      chk("c15_rd_sel", rd_sel_o,   0);
      chk("c15_ready",  ld_ready_o, 0);

      cyc(); cu_done_i = 4'b0000; #1;
      chk("c16_rd_sel", rd_sel_o,      1);
      chk("c16_ready",  ld_ready_o,    1);
      chk("c16_start",  chunk_start_o, 0);
      chk("c16_full",   bank_full_o,   2'b10);

      cyc(); #1;
      chk("c17_start",  chunk_start_o, 1);
      chk("c17_rd_sel", rd_sel_o,      1);
      chk("c17_shift",  shift_left_o,  3);
      chk("c17_full",   bank_full_o,   2'b00);

      // ---------------- partial enable 0101 ----------------
      cyc(); cu_en_i = 4'b0101; cu_done_i = 4'b0010; #1;
      chk("c18_start", chunk_start_o, 0);

      cyc(); cu_done_i = 4'b0001; #1;
      chk("c19_rd_sel", rd_sel_o, 1);

      cyc(); cu_done_i = 4'b0100; #1;
      chk("c20_rd_sel", rd_sel_o, 1);

      cyc(); cu_done_i = 4'b0000; #1;
      chk("c21_rd_sel", rd_sel_o,    0);
      chk("c21_full",   bank_full_o, 2'b00);

      // ---------------- reset mid-fill ----------------
      cyc(); ld_valid_i = 1'b1; ld_shift_i = 5'd7; #1;
      chk("d0_wr_count", wr_count_o, 0);
      cyc(); #1;
      cyc(); rst_i = 1'b1; #1;
      chk("d2_wr_count", wr_count_o, 2);
      chk("d2_ready",    ld_ready_o, 0);
      chk("d2_wr_valid", wr_valid_o, 0);

      cyc(); rst_i = 1'b0; ld_valid_i = 1'b0; #1;
      chk("d3_wr_count", wr_count_o,      0);
      chk("d3_wr_sel",   wr_sel_o,        0);
      chk("d3_full",     bank_full_o,     0);
      chk("d3_ready",    ld_ready_o,      1);
      chk("d3_start",    chunk_start_o,   0);
      chk("d3_perf_wr",  perf_wr_stall_o, 0);

      // ---------------- fresh fill, all CUs disabled ----------------
      cu_en_i = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         cyc();
         ld_valid_i = 1'b1;
         ld_shift_i = (i == 0) ? 5'd5 : 5'd2;
         #1;
         chk($sformatf("e%0d_wr_count", i), wr_count_o,    i);
         chk($sformatf("e%0d_wr_sel", i),   wr_sel_o,      0);
         chk($sformatf("e%0d_start", i),    chunk_start_o, 0);
      end

      cyc(); ld_valid_i = 1'b0; #1;
      chk("e4_wr_sel", wr_sel_o,    1);
      chk("e4_full",   bank_full_o, 2'b01);

      cyc(); #1;
      chk("e5_start",  chunk_start_o, 1);
      chk("e5_shift",  shift_left_o,  5);
      chk("e5_rd_sel", rd_sel_o,      0);

      cyc(); #1;
      chk("e6_start",  chunk_start_o, 0);
      chk("e6_rd_sel", rd_sel_o,      0);

      cyc(); #1;
      chk("e7_rd_sel", rd_sel_o,    1);
      chk("e7_full",   bank_full_o, 2'b00);
      chk("e7_shift",  shift_left_o, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ifm_chunk_pingpong_ctrl.md
# ifm_chunk_pingpong_ctrl

Sequencing controller for the double-buffered IFM non-padding chunk store (two chunk banks, each a sparsemap plus nonzero-data buffer).
- Write side: accepts chunk beats from the IFM loader and drives the store's write controls (`wr_valid`, `wr_count`, `wr_sel`).
- Read side: tracks per-bank fill/consume state, then launches each full chunk to the compute units with `chunk_start`, `rd_sel` and the chunk's `shift_left`.
- Release: frees a bank once every enabled compute unit reports it has consumed the chunk.

## Interface
Parameters:
- MEM_SIZE, 128, chunk size in elements
- BUS_SIZE, 32, elements per write beat; WR_CYC_NUM = MEM_SIZE/BUS_SIZE (4)
- PREFIX_SUM_SIZE, 32, sparsemap read window; sets shift width SW = $clog2(PREFIX_SUM_SIZE)
- COMPUTE_UNIT_NUM, 4, number of compute units (CU)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock
  - rst_i  in  1  synchronous active-high reset
- Loader side:
  - ld_valid_i  in  1  loader beat valid
  - ld_ready_o  out  1  beat accepted when ld_valid_i && ld_ready_o
  - ld_shift_i  in  SW  chunk shift; sampled on the first beat of a chunk only
- Store write controls:
  - wr_valid_o  out  1  write strobe to store (= ld_valid_i && ld_ready_o)
  - wr_count_o  out  $clog2(WR_CYC_NUM)  beat index within chunk
  - wr_sel_o  out  1  bank being filled
- Store read controls:
  - chunk_start_o  out  1  one-cycle launch pulse
  - rd_sel_o  out  1  bank being read
  - shift_left_o  out  SW  shift of the launched chunk
- CU side:
  - cu_en_i  in  COMPUTE_UNIT_NUM  quasi-static CU enables
  - cu_done_i  in  COMPUTE_UNIT_NUM  per-CU one-cycle "chunk consumed" pulse
- Status:
  - bank_full_o  out  2  bank holds an unlaunched full chunk
  - perf_wr_stall_o  out  16  see Configuration
  - perf_rd_stall_o  out  16  see Configuration

## Operation
Bank state:
- Each bank has a 2-bit state: EMPTY, FILLING, FULL, READING. Per-bank SW-bit shift register.
- Write pointer wp (= wr_sel_o) and read pointer rp (= rd_sel_o).

Write path:
- ld_ready_o = !rst_i && bank[wp] ∈ {EMPTY, FILLING}. Derived from registered state only; no combinational path from ld_valid_i.
- On an accepted beat with bank EMPTY: bank becomes FILLING, ld_shift_i is captured into shift[wp], wr_count increments.
- On an accepted beat with wr_count == WR_CYC_NUM-1: bank becomes FULL, wr_count wraps to 0, wp toggles.

Read FSM:
- R_IDLE → R_START when bank[rp] == FULL.
  - At the same edge: bank[rp] becomes READING, done_mask is cleared, shift_left_o is loaded from shift[rp].
- R_START (one cycle): chunk_start_o = 1. cu_done_i is ignored. Next state is R_BUSY.
- R_BUSY: done_mask |= cu_done_i & cu_en_i.
  - When (done_mask | (cu_done_i & cu_en_i) | ~cu_en_i) is all-ones: bank[rp] becomes EMPTY, rp toggles, next state is R_IDLE.
- cu_en_i == 0 releases the bank on the first R_BUSY cycle.
- Repeated done pulses from a CU are harmless.

Status and boundary cases:
- bank_full_o[b] = (bank[b] == FULL).
- Both banks FULL/READING: ld_ready_o = 0 until release.
- Release and a new fill of the same bank: the release edge sets EMPTY; ld_ready_o rises the next cycle.
- Release and a FULL other bank: R_IDLE is entered, then R_START follows the next cycle. There is no back-to-back chunk_start.
- Reset mid-operation: all state returns to reset values. Store contents are not cleared; they are treated as invalid.

## Timing
Reset values:
- ld_ready_o = 0 during reset and 1 the first cycle after.
- wr_valid_o = 0, wr_count_o = 0, wr_sel_o = 0.
- chunk_start_o = 0, rd_sel_o = 0, shift_left_o = 0.
- bank_full_o = 0, perf counters = 0.
- Banks EMPTY, read FSM in R_IDLE.

Latencies:
- wr_valid_o is combinational, same cycle as the beat.
- wr_count_o and wr_sel_o update at the edge after the accepted beat.
- Last beat in cycle t → bank_full_o in cycle t+1 → chunk_start_o in cycle t+2.
- Final cu_done_i in cycle u → bank EMPTY and rd_sel_o toggled in cycle u+1.
- rd_sel_o and shift_left_o are stable from the chunk_start_o cycle until release.

## Configuration
IFM_CHUNK_CTRL_PERF_EN:
- Defined:
  - perf_wr_stall_o counts cycles with ld_valid_i && !ld_ready_o.
  - perf_rd_stall_o counts R_IDLE cycles with no FULL bank at rp.
  - Both counters are 16-bit, saturating at 16'hFFFF, and cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Reset, then ld_valid_i high for 4 cycles with ld_shift_i = 5 on beat 0 → wr_count_o 0,1,2,3 with wr_sel_o = 0; then wr_sel_o = 1, bank_full_o = 2'b01; chunk_start_o pulses 2 cycles after the last beat with rd_sel_o = 0 and shift_left_o = 5.
- Stream 12 beats with no cu_done_i → beats 0–7 accepted; ld_ready_o = 0 from beat 8; chunk_start_o pulses once only. With PERF_EN, perf_wr_stall_o = 4 after 4 stalled cycles.
- cu_en_i = 4'hF, cu_done_i pulses 4'b0001, 4'b0100, 4'b0010, 4'b1000 on separate cycles → bank 0 stays READING until the cycle after the 4th pulse; then rd_sel_o = 1 and ld_ready_o reasserts.
- cu_en_i = 4'b0101, done from CU0 and CU2 only → bank released; done from CU1 while disabled has no effect.
- Bank 0 ld_shift_i = 5, bank 1 ld_shift_i = 3, all CUs done after each chunk → shift_left_o = 5 then 3; rd_sel_o 0 then 1; second chunk_start_o ≥2 cycles after release.
- Reset asserted at wr_count_o = 2 mid-fill → next cycle wr_count_o = 0, wr_sel_o = 0, bank_full_o = 0; no chunk_start_o; a fresh 4-beat fill behaves as in scenario 1.
